// File: rtl/dvp_frame_source.sv
// OV7670-style DVP byte-stream source: replays a 320x240 RGB444 frame buffer
// as 640x480 RGB565 (2x pixel and line duplication) with vsync/href framing.
module dvp_frame_source #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 784,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 510,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17
) (
    input  logic        p_clock,
    input  logic        rst,
    input  logic        enable,
    input  logic [11:0] bram_rdata,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  p_data,
    output logic [16:0] bram_addr,
    output logic        bram_re,
    output logic        frame_start,
    output logic        busy
);

    localparam int LINE_BYTES = 2 * H_TOTAL;
    localparam int HW         = $clog2(LINE_BYTES + 1);
    localparam int VW         = $clog2(V_TOTAL + 1);
    localparam int ACT_FIRST  = VSYNC_LINES + V_BACK;
    localparam int ACT_END    = ACT_FIRST + V_ACTIVE;

    localparam logic [HW-1:0] H_LAST      = HW'(LINE_BYTES - 1);
    localparam logic [HW-1:0] H_ACT_BYTES = HW'(2 * H_ACTIVE);
    localparam logic [HW-1:0] H_ONE       = HW'(1);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VS_END    = VW'(VSYNC_LINES);
    localparam logic [VW-1:0] V_ACT_FIRST = VW'(ACT_FIRST);
    localparam logic [VW-1:0] V_ACT_END   = VW'(ACT_END);
    localparam logic [VW-1:0] V_ONE       = VW'(1);
    localparam logic [16:0]   ROW_WORDS   = 17'(H_ACTIVE / 2);

    typedef enum logic [2:0] {IDLE, VSYNC, BACK, ACTIVE, FRONT} state_t;

    // Per-slot sideband that travels alongside the BRAM read.
    typedef struct packed {
        logic vs;
        logic hr;
        logic fs;
        logic odd;
    } side_t;

    state_t          state, state_n;
    logic [HW-1:0]   hcnt, hcnt_n;
    logic [VW-1:0]   vcnt, vcnt_n;
    logic            h_wrap, v_last;
    logic            vs_c, hr_c, fs_c, rd_c;
    logic [VW-1:0]   line_idx;
    logic [16:0]     addr_c;
    side_t           side_c;
    side_t [1:0]     side_pipe;
    logic [11:0]     word_q;
    logic            act, act_n;
    logic [1:0]      act_d;

    function automatic state_t line_state(input logic [VW-1:0] idx);
        if (idx < V_VS_END)         return VSYNC;
        else if (idx < V_ACT_FIRST) return BACK;
        else if (idx < V_ACT_END)   return ACTIVE;
        else                        return FRONT;
    endfunction

    function automatic logic [7:0] pack_byte0(input logic [11:0] w);
        return {w[11:8], w[11], w[7:5]};
    endfunction

    function automatic logic [7:0] pack_byte1(input logic [11:0] w);
        return {w[4], w[7:6], w[3:0], w[3]};
    endfunction

    assign h_wrap = (hcnt == H_LAST);
    assign v_last = (vcnt == V_LAST);

    always_ff @(posedge p_clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            state <= state_n;
            hcnt  <= hcnt_n;
            vcnt  <= vcnt_n;
        end
    end

    // State only changes at line wrap; enable is looked at only on frame entry.
    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        vcnt_n  = vcnt;
        if (state == IDLE) begin
            hcnt_n = '0;
            vcnt_n = '0;
            if (enable) state_n = VSYNC;
        end else begin
            hcnt_n = h_wrap ? '0 : hcnt + H_ONE;
            if (h_wrap) begin
                if (v_last) begin
                    vcnt_n  = '0;
                    state_n = enable ? VSYNC : IDLE;
                end else begin
                    vcnt_n  = vcnt + V_ONE;
                    state_n = line_state(vcnt + V_ONE);
                end
            end
        end
    end

    always_comb begin
        vs_c     = (state == VSYNC);
        hr_c     = (state == ACTIVE) && (hcnt < H_ACT_BYTES);
        fs_c     = vs_c && (hcnt == '0) && (vcnt == '0);
        rd_c     = hr_c && !hcnt[0];
        line_idx = vcnt - V_ACT_FIRST;
        // Line pairs share a source row; byte quads share a source word.
        addr_c   = 17'(line_idx >> 1) * ROW_WORDS + 17'(hcnt >> 2);
        side_c.vs  = vs_c;
        side_c.hr  = hr_c;
        side_c.fs  = fs_c;
        side_c.odd = hcnt[0];
        act      = (state != IDLE);
        act_n    = (state_n != IDLE);
    end

    always_ff @(posedge p_clock or posedge rst) begin
        if (rst) begin
            bram_re   <= 1'b0;
            bram_addr <= '0;
            side_pipe <= '0;
        end else begin
            bram_re   <= rd_c;
            if (rd_c) bram_addr <= addr_c;
            side_pipe <= {side_pipe[0], side_c};
        end
    end

    // Output stage: byte0 packs straight from BRAM, byte1 reuses the held word.
    always_ff @(posedge p_clock or posedge rst) begin
        if (rst) begin
            vsync       <= 1'b0;
            href        <= 1'b0;
            frame_start <= 1'b0;
            p_data      <= '0;
            word_q      <= '0;
        end else begin
            vsync       <= side_pipe[1].vs;
            href        <= side_pipe[1].hr;
            frame_start <= side_pipe[1].fs;
            if (side_pipe[1].hr) begin
                if (!side_pipe[1].odd) begin
                    word_q <= bram_rdata;
                    p_data <= pack_byte0(bram_rdata);
                end else begin
                    p_data <= pack_byte1(word_q);
                end
            end else begin
                p_data <= '0;
            end
        end
    end

    // busy rises with the IDLE exit and holds until the pipeline has drained.
    always_ff @(posedge p_clock or posedge rst) begin
        if (rst) begin
            act_d <= '0;
            busy  <= 1'b0;
        end else begin
            act_d <= {act_d[0], act};
            busy  <= act_n | act | act_d[0] | act_d[1];
        end
    end

endmodule

// File: tb/tb_dvp_frame_source.sv
// Directed/randomized bench for dvp_frame_source at small geometry, checked
// against a position-in-frame model of the DVP stream.
module tb_dvp_frame_source;

    localparam int HA = 8, HT = 12, VA = 4, VT = 10, VS = 2, VB = 2;
    localparam int LB = 2 * HT;
    localparam int FRAME = VT * LB;
    localparam int ACT0 = VS + VB;

    logic        p_clock = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] bram_rdata;
    logic        vsync, href, bram_re, frame_start, busy;
    logic [7:0]  p_data;
    logic [16:0] bram_addr;

    int checks = 0;
    int errors = 0;
    bit pack_chk = 1'b0;
    logic [11:0] mem [0:127];

    always #5 p_clock = ~p_clock;

    dvp_frame_source #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
        .VSYNC_LINES(VS), .V_BACK(VB)
    ) dut (
        .p_clock(p_clock), .rst(rst), .enable(enable), .bram_rdata(bram_rdata),
        .vsync(vsync), .href(href), .p_data(p_data), .bram_addr(bram_addr),
        .bram_re(bram_re), .frame_start(frame_start), .busy(busy)
    );

    always @(posedge p_clock) if (bram_re) bram_rdata <= mem[bram_addr[6:0]];

    function automatic bit m_vs(input int p);
        return (p / LB) < VS;
    endfunction

    function automatic bit m_hr(input int p);
        int ln;
        ln = p / LB;
        return (ln >= ACT0) && (ln < ACT0 + VA) && ((p % LB) < 2 * HA);
    endfunction

    function automatic int m_addr(input int p);
        return ((p / LB - ACT0) / 2) * (HA / 2) + (p % LB) / 4;
    endfunction

    function automatic logic [7:0] m_pd(input int p);
        logic [11:0] w;
        logic [15:0] rgb;
        if (!m_hr(p)) return 8'h00;
        w   = mem[m_addr(p)];
        rgb = {w[11:8], w[11], w[7:4], w[7:6], w[3:0], w[3]};
        return (p % 2 == 0) ? rgb[15:8] : rgb[7:0];
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_pos(input int k, input int p, input bit live);
        bit re_e;
        re_e = live && (p + 2 < FRAME) && m_hr(p + 2) && ((p % 2) == 0);
        chk("vsync", k, vsync, live && m_vs(p));
        chk("href", k, href, live && m_hr(p));
        chk("p_data", k, p_data, live ? m_pd(p) : 8'h00);
        chk("frame_start", k, frame_start, live && (p == 0));
        chk("busy", k, busy, live);
        chk("bram_re", k, bram_re, re_e);
        if (re_e) chk("bram_addr", k, bram_addr, m_addr(p + 2));
        if (live && pack_chk && p == ACT0 * LB)     chk("pack_b0", k, p_data, 8'hF8);
        if (live && pack_chk && p == ACT0 * LB + 1) chk("pack_b1", k, p_data, 8'h15);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_vsync"}, -1, vsync, 0);
        chk({tag, "_href"}, -1, href, 0);
        chk({tag, "_p_data"}, -1, p_data, 0);
        chk({tag, "_bram_re"}, -1, bram_re, 0);
        chk({tag, "_bram_addr"}, -1, bram_addr, 0);
        chk({tag, "_frame_start"}, -1, frame_start, 0);
        chk({tag, "_busy"}, -1, busy, 0);
    endtask

    // Three cycles of pipeline latency after the first enabled edge.
    task automatic pre_start();
        for (int i = 0; i < 3; i++) begin
            @(negedge p_clock);
            chk("lat_vsync", i, vsync, 0);
            chk("lat_busy", i, busy, 1);
        end
        @(negedge p_clock);
    endtask

    task automatic run(input int total, input int drop_at);
        for (int k = 0; k < total; k++) begin
            check_pos(k, k % FRAME, 1'b1);
            if (k == drop_at) enable = 1'b0;
            @(negedge p_clock);
        end
    endtask

    always @(negedge p_clock) begin
        if (!rst) begin
            chk("href_vsync_excl", -1, href & vsync, 0);
            chk("p_data_blank", -1, (!href && p_data != 8'h00), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 12'($urandom);
        mem[0] = 12'hF0A;

        repeat (3) @(negedge p_clock);
        check_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge p_clock);
            check_pos(i, 0, 1'b0);
        end

        // Three back-to-back frames, enable dropped mid-ACTIVE of the third.
        enable   = 1'b1;
        pack_chk = 1'b1;
        pre_start();
        run(3 * FRAME, 2 * FRAME + ACT0 * LB + 30);
        pack_chk = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_pos(3 * FRAME + i, 0, 1'b0);
            @(negedge p_clock);
        end

        // New random image; restart and reset mid-href.
        for (int i = 0; i < 128; i++) mem[i] = 12'($urandom);
        enable = 1'b1;
        pre_start();
        run(FRAME + 6 * LB + 6, -1);
        chk("href_before_rst", -1, href, 1);
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge p_clock);
        rst = 1'b0;
        pre_start();
        run(FRAME, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
